// File: rtl/ifu.sv
// ---------------------------------------------------------------------------
// ifu -- Instruction Fetch Unit
//
// Owns the fetch PC and issues in-order word reads to instruction memory.
// Returned words land in a small FIFO that feeds decode through a
// valid/ready handshake. A redirect from execute flushes the FIFO, retargets
// both PCs and arranges for every still-in-flight response to be discarded.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   ifu_req_*       fetch request channel (valid/ready, word-aligned addr)
//   ifu_rsp_*       fetch response channel (valid, data, err), no backpressure
//   redirect*       single-cycle PC redirect from execute
//   inst_*          instruction stream to decode (valid/ready, inst, pc, fault)
// ---------------------------------------------------------------------------
module ifu #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h8000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,

    output logic            ifu_req_valid,
    input  logic            ifu_req_ready,
    output logic [XLEN-1:0] ifu_req_addr,

    input  logic            ifu_rsp_valid,
    input  logic [XLEN-1:0] ifu_rsp_data,
    input  logic            ifu_rsp_err,

    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,

    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_fault
);

    // Counter width holds 0..FIFO_DEPTH; pointer width indexes the buffer.
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] pc;
        logic            err;
    } entry_t;

    entry_t          mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;

    logic [CW:0]     used;
    logic            have_credit;
    logic            req_fire;
    logic            rsp_accept;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] target_pc;

    // -----------------------------------------------------------------------
    // Issue control
    //
    // A request is only allowed while outstanding + buffered < depth, so every
    // response is guaranteed a free FIFO slot and the response channel never
    // needs backpressure. rst gates valid so it drops combinationally with the
    // asynchronous reset instead of waiting for a clock.
    // -----------------------------------------------------------------------
    always_comb begin
        used          = {1'b0, outstanding} + {1'b0, count};
        have_credit   = used < DEPTH_C;
        ifu_req_valid = have_credit & ~redirect & ~rst;
        ifu_req_addr  = fetch_pc;
        req_fire      = ifu_req_valid & ifu_req_ready;
    end

    // -----------------------------------------------------------------------
    // Response / pop qualification
    //
    // A response with nothing outstanding is a protocol violation and is
    // ignored entirely so the counters cannot underflow. Redirect wins over
    // both the push of a response and a decode pop in the same cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        rsp_accept = ifu_rsp_valid & (outstanding != '0);
        push       = rsp_accept & ~redirect & (drop_cnt == '0);
        pop        = inst_valid & inst_ready & ~redirect;
        target_pc  = redirect_pc & ~XLEN'(3);
    end

    // -----------------------------------------------------------------------
    // Fetch state
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            // Outstanding always tracks the memory side, redirect or not:
            // requests already issued will still come back.
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_accept);

            if (redirect) begin
                fetch_pc <= target_pc;
                rsp_pc   <= target_pc;
                // Everything still in flight after this cycle is stale.
                // No request issues during redirect, so this equals the
                // post-update outstanding count.
                drop_cnt <= outstanding - CW'(rsp_accept);
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + XLEN'(4);
                if (rsp_accept && drop_cnt != '0)
                    drop_cnt <= drop_cnt - CW'(1);
                if (push)
                    rsp_pc <= rsp_pc + XLEN'(4);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Instruction buffer
    //
    // Storage is reset so the head fields read as zero out of reset. A flush
    // only clears pointers and count; stale contents are masked by
    // inst_valid. Pointers wrap naturally because depth is a power of two.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{data: ifu_rsp_data, pc: rsp_pc, err: ifu_rsp_err};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Head of the buffer drives decode directly; no bypass from the response
    // port, so a response in cycle N becomes visible in cycle N+1.
    always_comb begin
        inst_valid = (count != '0);
        inst       = mem[rd_ptr].data;
        inst_pc    = mem[rd_ptr].pc;
        inst_fault = mem[rd_ptr].err;
    end

endmodule

// File: doc/ifu.md
Name: ifu

Overview:
- Instruction Fetch Unit; the producer side of the instruction stream consumed by the decode unit.
- Owns the fetch PC and issues in-order word reads over a request/response instruction-memory interface.
- Buffers returned words in a small FIFO and presents instruction, PC and fault to decode with a valid/ready handshake.
- Accepts taken-branch/jump redirects from execute: flushes the buffer and discards stale in-flight responses.

Parameters:
- XLEN, 32, data/address width.
- RESET_PC, 32'h8000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries; also the cap on outstanding requests plus buffered entries (power of 2, >=2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- ifu_req_valid  out  1  fetch request valid.
- ifu_req_ready  in  1  memory accepts request.
- ifu_req_addr  out  XLEN  word-aligned fetch address.
- ifu_rsp_valid  in  1  read response valid. Always accepted, no backpressure.
- ifu_rsp_data  in  XLEN  instruction word.
- ifu_rsp_err  in  1  access fault for this response.
- redirect  in  1  PC redirect from execute.
- redirect_pc  in  XLEN  redirect target. Bits [1:0] are ignored and forced to 0.
- inst_valid  out  1  buffered instruction available.
- inst_ready  in  1  decode consumes instruction.
- inst  out  XLEN  instruction word to decode.
- inst_pc  out  XLEN  PC of inst.
- inst_fault  out  1  inst came from an erroring fetch.

Behaviour:
- Reset (async assert, sync release):
  - fetch_pc = RESET_PC; rsp_pc = RESET_PC.
  - outstanding = 0; drop_cnt = 0; FIFO empty.
  - ifu_req_valid = 0, inst_valid = 0, inst = 0, inst_pc = 0, inst_fault = 0 while rst is high.
- Request issue:
  - credits = FIFO_DEPTH - outstanding - fifo_count.
  - ifu_req_valid = (credits > 0) & ~redirect.
  - ifu_req_addr = fetch_pc.
  - First request is asserted the first cycle after reset release.
- Handshake: on ifu_req_valid & ifu_req_ready, fetch_pc += 4 (wraps mod 2^XLEN) and outstanding increments.
  - While ifu_req_ready = 0, addr is held stable.
  - ifu_req_valid may drop only because of redirect or a credit change caused by redirect.
- Responses:
  - Returned strictly in request order; each ifu_rsp_valid decrements outstanding.
  - If drop_cnt > 0: the response is discarded and drop_cnt decrements.
  - Otherwise: push {ifu_rsp_data, rsp_pc, ifu_rsp_err} into the FIFO, then rsp_pc += 4.
  - Fetching continues after an error response.
- ifu_rsp_valid with outstanding == 0 is a protocol violation: ignored, no state change.
- Credit rule: a response never finds the FIFO full, since requests are capped by credits.
- Counter widths: outstanding and drop_cnt are $clog2(FIFO_DEPTH+1) bits; neither over- nor under-flows under legal traffic.
- Output: inst_valid = FIFO non-empty; inst/inst_pc/inst_fault = head entry, registered.
- Pop on inst_valid & inst_ready. inst_ready is ignored when inst_valid = 0.
- Latency: response in cycle N gives inst_valid in cycle N+1. There is no bypass; an empty FIFO stays empty in cycle N.
- FIFO pointers wrap modulo FIFO_DEPTH. Push and pop in the same cycle keeps the count unchanged.
- Redirect (single-cycle pulse, highest priority). The same cycle:
  - ifu_req_valid is forced 0.
  - Any response arriving is dropped.
  - Any decode pop is ignored.
- Redirect, next state:
  - FIFO flushed (count 0).
  - fetch_pc = rsp_pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - drop_cnt = outstanding - (ifu_rsp_valid ? 1 : 0).
  - outstanding is updated normally.
- Back-to-back redirects: the latest wins; drop_cnt is recomputed from current outstanding.
- Async reset mid-operation clears all state immediately; in-flight memory responses after release are the system's responsibility (memory is reset together).

Test Plan:
- Reset release, ifu_req_ready=1, memory returns 0x00100093 one cycle after each request -> req addrs 0x80000000, 0x80000004…; first inst_valid two cycles after first handshake with inst=0x00100093, inst_pc=0x80000000.
- inst_ready=0, immediate responses -> exactly FIFO_DEPTH=2 requests (0x80000000, 0x80000004) then ifu_req_valid=0. inst_ready=1 for one pop -> exactly one new request to 0x80000008.
- Two requests outstanding, redirect to 0x80000102 -> next req addr 0x80000100; the two old responses dropped; next inst_pc=0x80000100. Redirect coincident with a response: that response is also dropped.
- ifu_req_ready=0 for 5 cycles -> ifu_req_valid=1, addr held at 0x80000000, outstanding stays 0, no inst_valid.
- Response with ifu_rsp_err=1 for PC 0x80000004 -> inst_fault=1, inst_pc=0x80000004; the following entry has inst_fault=0.
- Assert rst mid-stream with FIFO full -> inst_valid, ifu_req_valid drop in the same cycle (async). After release, the first request is to 0x80000000.
